// File: rtl/can_tx_stuffer.sv
// CAN transmit bit-stream stage: accumulates CRC-15, appends it MSB first and
// inserts complement stuff bits after STUFF_LEN equal bits, SOF through CRC.
module can_tx_stuffer #(
  parameter int unsigned STUFF_LEN = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_tick,
  input  logic        abort,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        in_sof,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tx_bit,
  output logic        tx_active,
  output logic [14:0] crc_out,
  output logic        frame_done,
  output logic        underrun
);

  localparam int unsigned CRC_W = 15;
  localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned IDX_W = 4;
  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {IDLE, DATA, CRC, TAIL} state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_bit_d, tx_active_d, frame_done_d, underrun_d;
  logic             stuff_pend;
  logic [RUN_W-1:0] run_inc;
  logic             crc_bit;

  // One MSB-first step of the CAN CRC-15 shift register
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = b ^ c[CRC_W-1];
    crc_step = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
  endfunction

  assign stuff_pend = (run_q == RUN_W'(STUFF_LEN));
  assign run_inc    = stuff_pend ? run_q : run_q + RUN_W'(1);
  assign crc_bit    = crc_q[idx_q];
  assign crc_out    = crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_q      <= '0;
      last_q     <= 1'b1;
      crc_q      <= '0;
      idx_q      <= '0;
      tx_bit     <= 1'b1;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      idx_q      <= idx_d;
      tx_bit     <= tx_bit_d;
      tx_active  <= tx_active_d;
      frame_done <= frame_done_d;
      underrun   <= underrun_d;
    end
  end

  // Next-state, serializer and handshake logic; abort overrides everything
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    last_d       = last_q;
    crc_d        = crc_q;
    idx_d        = idx_q;
    tx_bit_d     = tx_bit;
    tx_active_d  = tx_active;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    in_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = bit_tick & in_valid & in_sof;
        if (in_ready) begin
          crc_d       = crc_step(CRC_W'(0), in_bit);
          tx_bit_d    = in_bit;
          last_d      = in_bit;
          run_d       = RUN_W'(1);
          tx_active_d = 1'b1;
          idx_d       = IDX_W'(14);
          state_d     = in_last ? CRC : DATA;
        end
      end
      DATA: begin
        in_ready = bit_tick & in_valid & ~stuff_pend;
        if (bit_tick) begin
          if (stuff_pend) begin
            tx_bit_d = ~last_q;
            last_d   = ~last_q;
            run_d    = RUN_W'(1);
          end else if (in_valid) begin
            crc_d    = crc_step(crc_q, in_bit);
            tx_bit_d = in_bit;
            last_d   = in_bit;
            run_d    = (in_bit == last_q) ? run_inc : RUN_W'(1);
            if (in_last) begin
              idx_d   = IDX_W'(14);
              state_d = CRC;
            end
          end else begin
            underrun_d  = 1'b1;
            tx_bit_d    = 1'b1;
            tx_active_d = 1'b0;
            run_d       = '0;
            state_d     = IDLE;
          end
        end
      end
      CRC: begin
        if (bit_tick) begin
          if (stuff_pend) begin
            tx_bit_d = ~last_q;
            last_d   = ~last_q;
            run_d    = RUN_W'(1);
          end else begin
            tx_bit_d = crc_bit;
            last_d   = crc_bit;
            run_d    = (crc_bit == last_q) ? run_inc : RUN_W'(1);
            idx_d    = idx_q - IDX_W'(1);
            if (idx_q == '0) state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (bit_tick) begin
          if (stuff_pend) begin
            tx_bit_d = ~last_q;
            last_d   = ~last_q;
            run_d    = RUN_W'(1);
          end else begin
            tx_bit_d     = 1'b1;
            tx_active_d  = 1'b0;
            frame_done_d = 1'b1;
            run_d        = '0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      in_ready     = 1'b0;
      state_d      = IDLE;
      run_d        = '0;
      last_d       = last_q;
      crc_d        = crc_q;
      idx_d        = idx_q;
      tx_bit_d     = 1'b1;
      tx_active_d  = 1'b0;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_can_tx_stuffer.sv
// Directed bench for can_tx_stuffer: hand-computed stuffed streams and CRCs.
module tb_can_tx_stuffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_tick, abort, in_valid, in_bit, in_sof, in_last;
  logic        in_ready, tx_bit, tx_active, frame_done, underrun;
  logic [14:0] crc_out;

  int n_pass  = 0;
  int n_total = 0;
  logic rdy_log [0:63];

  can_tx_stuffer #(.STUFF_LEN(5)) dut (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .abort(abort),
    .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof), .in_last(in_last),
    .in_ready(in_ready), .tx_bit(tx_bit), .tx_active(tx_active),
    .crc_out(crc_out), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One tick cycle: inputs set at negedge, in_ready captured before the edge,
  // outputs visible 1ns after the edge
  task automatic tick(input logic v, input logic b, input logic s, input logic l,
                      input logic a, output logic rdy);
    @(negedge clk);
    in_valid = v; in_bit = b; in_sof = s; in_last = l; abort = a; bit_tick = 1'b1;
    #1 rdy = in_ready;
    @(posedge clk);
    #1;
    bit_tick = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_last = 1'b0; abort = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Feed data (MSB first) holding each bit until accepted, check every line bit
  task automatic run_frame(input string tag, input logic [7:0] data, input int ndata,
                           input logic [31:0] stream, input int nstream, input logic [14:0] exp_crc);
    int   ptr;
    logic rdy;
    ptr = 0;
    for (int i = 0; i < nstream; i++) begin
      if (ptr < ndata)
        tick(1'b1, data[ndata-1-ptr], ptr == 0, ptr == ndata-1, 1'b0, rdy);
      else
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
      rdy_log[i] = rdy;
      if (rdy) ptr++;
      check($sformatf("%s tx_bit[%0d]", tag, i), 32'(tx_bit), 32'(stream[nstream-1-i]));
      if (tx_active !== 1'b1 || frame_done !== 1'b0)
        check($sformatf("%s active/done[%0d]", tag, i), {30'd0, tx_active, frame_done}, 32'h2);
    end
    check({tag, " crc"}, 32'(crc_out), 32'(exp_crc));
    check({tag, " done_early"}, 32'(frame_done), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    check({tag, " frame_done"}, 32'(frame_done), 32'd1);
    check({tag, " end_tx_bit"}, 32'(tx_bit), 32'd1);
    check({tag, " end_active"}, 32'(tx_active), 32'd0);
    idle_cycle();
    check({tag, " done_pulse"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    logic rdy;
    rst_n = 1'b0;
    bit_tick = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    in_sof = 1'b0; in_last = 1'b0;
    #12;
    check("rst tx_bit", 32'(tx_bit), 32'd1);
    check("rst tx_active", 32'(tx_active), 32'd0);
    check("rst crc", 32'(crc_out), 32'd0);
    check("rst pulses", {30'd0, frame_done, underrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-frame asynchronous reset
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rdy);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    check("pre-rst tx_bit", 32'(tx_bit), 32'd0);
    check("pre-rst active", 32'(tx_active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst tx_bit", 32'(tx_bit), 32'd1);
    check("async rst active", 32'(tx_active), 32'd0);
    check("async rst crc", 32'(crc_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single 0 bit: 16 zeros become 19 line bits with three stuff bits
    run_frame("zero", 8'h00, 1, 32'(19'b0000010000010000010), 19, 15'h0000);
    // Single 1 bit: CRC 0x4599 with no stuff bits
    run_frame("one", 8'h01, 1, 32'(16'b1100010110011001), 16, 15'h4599);
    // 0111110: stuff 0 after the fifth 1, CRC 0x14DA
    run_frame("stuff", 8'h3E, 7, 32'(23'b01111100001010011011010), 23, 15'h14DA);
    check("stuff rdy before", 32'(rdy_log[5]), 32'd1);
    check("stuff rdy on stuff tick", 32'(rdy_log[6]), 32'd0);
    check("stuff rdy after", 32'(rdy_log[7]), 32'd1);

    // Underrun in DATA
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rdy);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rdy);
    check("ur pre tx_bit", 32'(tx_bit), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    check("ur pulse", 32'(underrun), 32'd1);
    check("ur tx_bit", 32'(tx_bit), 32'd1);
    check("ur active", 32'(tx_active), 32'd0);
    idle_cycle();
    check("ur pulse end", 32'(underrun), 32'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    check("idle no-sof rdy", 32'(rdy), 32'd0);
    check("idle no-sof active", 32'(tx_active), 32'd0);

    // Abort in CRC state at idx 7
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rdy);
    check("ab sof rdy", 32'(rdy), 32'd1);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    check("ab crc idx8 bit", 32'(tx_bit), 32'd1);
    check("ab pre active", 32'(tx_active), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rdy);
    check("ab tx_bit", 32'(tx_bit), 32'd1);
    check("ab active", 32'(tx_active), 32'd0);
    check("ab no done", 32'(frame_done), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    check("ab stays idle", {30'd0, tx_active, frame_done}, 32'd0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rdy);
    check("ab new sof rdy", 32'(rdy), 32'd1);
    check("ab new sof tx_bit", 32'(tx_bit), 32'd0);
    check("ab new sof active", 32'(tx_active), 32'd1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rdy);
    check("abort blocks rdy", 32'(rdy), 32'd0);
    check("abort2 active", 32'(tx_active), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
